// File: rtl/text_ovl_pkg.sv
// Shared types and helpers for the text overlay controller.
package text_ovl_pkg;

  typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} ctrl_state_e;

  localparam logic [7:0] SPACE_CODE = 8'h20;

  typedef logic [15:0] cell_addr_t;

  function automatic cell_addr_t cell_index(input logic [7:0]  col,
                                            input logic [7:0]  row,
                                            input int unsigned cols);
    return cell_addr_t'({8'd0, row} * 16'(cols) + {8'd0, col});
  endfunction

endpackage

// File: rtl/text_cell_ram.sv
// Character cell store: one write port, one registered read port (read-old-data on collision).
module text_cell_ram
  import text_ovl_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic       clk,
  input  logic       i_we,
  input  cell_addr_t i_waddr,
  input  logic [7:0] i_wdata,
  input  cell_addr_t i_raddr,
  output logic [7:0] o_rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr[AW-1:0]] <= i_wdata;
    r_rdata <= r_mem[i_raddr[AW-1:0]];
  end

  assign o_rdata = r_rdata;

  if (AW < 16) begin : g_unused
    logic w_unused;
    assign w_unused = ^{i_waddr[15:AW], i_raddr[15:AW]};
  end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Text cell buffer with two-producer round-robin write arbiter and a 2-stage pixel pipeline.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module text_overlay_ctrl
  import text_ovl_pkg::*;
#(
  parameter int unsigned COLS         = 32,
  parameter int unsigned ROWS         = 16,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vsync,
  input  logic [7:0]   char_x,
  input  logic [7:0]   char_y,
  input  logic [255:0] ascii_char,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [7:0]   a_col,
  input  logic [7:0]   a_row,
  input  logic [7:0]   a_code,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [7:0]   b_col,
  input  logic [7:0]   b_row,
  input  logic [7:0]   b_code,
  input  logic         clear_req,
  output logic         clear_busy,
  output logic         err_oor,
  input  logic [7:0]   cursor_col,
  input  logic [7:0]   cursor_row,
  output logic         pix_out
);

  localparam int unsigned DEPTH     = COLS * ROWS;
  localparam cell_addr_t  LAST_ADDR = cell_addr_t'(DEPTH - 1);
  localparam logic [8:0]  COLS_W    = 9'(COLS);
  localparam logic [8:0]  ROWS_W    = 9'(ROWS);

  ctrl_state_e r_state;
  cell_addr_t  r_clr_addr;
  logic        r_prio_b;
  logic        r_err;
  logic        r_rd_vld;
  logic        r_pix;

  logic       w_idle, w_xfer, w_wr_in, w_rd_in, w_we, w_inv;
  logic [7:0] w_col, w_row, w_code, w_wdata, w_rd_code;
  cell_addr_t w_waddr, w_raddr;

  assign w_idle = (r_state == ST_IDLE);

  // r_prio_b set means B wins a tie; a pending clear suppresses both grants.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (w_idle && !clear_req) begin
      if (a_valid && (!b_valid || !r_prio_b)) a_ready = 1'b1;
      else if (b_valid)                       b_ready = 1'b1;
    end
  end

  assign w_xfer  = a_ready | b_ready;
  assign w_col   = b_ready ? b_col  : a_col;
  assign w_row   = b_ready ? b_row  : a_row;
  assign w_code  = b_ready ? b_code : a_code;
  assign w_wr_in = ({1'b0, w_col} < COLS_W) && ({1'b0, w_row} < ROWS_W);
  assign w_rd_in = ({1'b0, char_x} < COLS_W) && ({1'b0, char_y} < ROWS_W);

  assign w_we    = !w_idle || (w_xfer && w_wr_in);
  assign w_waddr = w_idle ? cell_index(w_col, w_row, COLS) : r_clr_addr;
  assign w_wdata = w_idle ? w_code : SPACE_CODE;
  assign w_raddr = w_rd_in ? cell_index(char_x, char_y, COLS) : '0;

  text_cell_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rd_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_prio_b   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_xfer && !w_wr_in;
      unique case (r_state)
        ST_CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 16'd1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
          end else if (w_xfer) begin
            r_prio_b <= a_ready;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_vld <= 1'b0;
      r_pix    <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_in && w_idle;
      r_pix    <= r_rd_vld && w_idle && (ascii_char[w_rd_code] ^ w_inv);
    end
  end

`ifdef CURSOR_BLINK_EN
  logic        r_vs, r_phase, r_cur_hit;
  logic [15:0] r_frame;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs      <= 1'b0;
      r_phase   <= 1'b0;
      r_cur_hit <= 1'b0;
      r_frame   <= '0;
    end else begin
      r_vs      <= vsync;
      r_cur_hit <= (char_x == cursor_col) && (char_y == cursor_row);
      if (vsync && !r_vs) begin
        if (r_frame == 16'(BLINK_FRAMES - 1)) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + 16'd1;
        end
      end
    end
  end

  assign w_inv = r_phase & r_cur_hit;
`else
  logic w_unused;
  assign w_unused = ^{vsync, cursor_col, cursor_row, 32'(BLINK_FRAMES)};
  assign w_inv    = 1'b0;
`endif

  assign clear_busy = (r_state == ST_CLEAR);
  assign err_oor    = r_err;
  assign pix_out    = r_pix;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Randomised bench for text_overlay_ctrl against a cycle-level behavioural model.
module tb_text_overlay_ctrl;

  localparam int COLS  = 32;
  localparam int ROWS  = 16;
  localparam int NCELL = COLS * ROWS;
  localparam int BLINK = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         vsync;
  logic [7:0]   char_x, char_y;
  logic [255:0] ascii_char;
  logic         a_valid, b_valid, a_ready, b_ready;
  logic [7:0]   a_col, a_row, a_code, b_col, b_row, b_code;
  logic         clear_req, clear_busy, err_oor, pix_out;
  logic [7:0]   cursor_col, cursor_row;

  always #5 clk = ~clk;

  text_overlay_ctrl #(
    .COLS         (COLS),
    .ROWS         (ROWS),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .char_x     (char_x),
    .char_y     (char_y),
    .ascii_char (ascii_char),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_col      (a_col),
    .a_row      (a_row),
    .a_code     (a_code),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_col      (b_col),
    .b_row      (b_row),
    .b_code     (b_code),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .err_oor    (err_oor),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .pix_out    (pix_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [7:0] mem [NCELL];
  int         clr_left;
  logic       favour_b;
  logic       exp_err, exp_pix;
  logic       p1_v, p1_cur;
  logic [7:0] p1_code;
  int         rises;
  logic       prev_vs;
  logic       g_a_grant, g_b_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_ascii();
    for (int k = 0; k < 8; k++) ascii_char[k*32 +: 32] = $urandom();
  endtask

  task automatic one_hot_ascii(input int code);
    ascii_char       = '0;
    ascii_char[code] = 1'b1;
  endtask

  // Inputs are already driven (just after a negedge); check handshake, advance one clock,
  // then check the registered outputs at the following negedge.
  task automatic cycle();
    logic       idle, ea, eb, xfer, wr_in, rd_in, cur_v, inv, new_pix;
    logic [7:0] wc, wr, wcode, cur_code;
    idle = (clr_left == 0);
    #1;
    ea = idle && !clear_req && a_valid && (!b_valid || !favour_b);
    eb = idle && !clear_req && b_valid && !ea;
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    g_a_grant = a_ready;
    g_b_grant = b_ready;
    xfer     = ea || eb;
    wc       = eb ? b_col  : a_col;
    wr       = eb ? b_row  : a_row;
    wcode    = eb ? b_code : a_code;
    wr_in    = (wc < COLS) && (wr < ROWS);
    rd_in    = (char_x < COLS) && (char_y < ROWS);
    cur_v    = idle && rd_in;
    cur_code = rd_in ? mem[char_y*COLS + char_x] : 8'h00;
    inv      = 1'b0;
`ifdef CURSOR_BLINK_EN
    inv = p1_cur && (((rises / BLINK) % 2) == 1);
`endif
    new_pix = p1_v && idle && (ascii_char[p1_code] ^ inv);
    @(posedge clk);
    exp_pix = new_pix;
    p1_v    = cur_v;
    p1_code = cur_code;
    p1_cur  = (char_x == cursor_col) && (char_y == cursor_row);
    exp_err = xfer && !wr_in;
    if (vsync && !prev_vs) rises++;
    prev_vs = vsync;
    if (clr_left > 0) begin
      mem[NCELL - clr_left] = 8'h20;
      clr_left--;
    end else if (clear_req) begin
      clr_left = NCELL;
    end else if (xfer) begin
      if (wr_in) mem[wr*COLS + wc] = wcode;
      favour_b = ea;
    end
    @(negedge clk);
    check("err_oor", err_oor, exp_err);
    check("pix_out", pix_out, exp_pix);
    check("clear_busy", clear_busy, clr_left > 0);
  endtask

  initial begin
    int cnt, grants;
    logic seen;

    reset = 1'b0; vsync = 1'b0; char_x = 0; char_y = 0; ascii_char = '1;
    a_valid = 1'b1; b_valid = 1'b1; a_col = 0; a_row = 0; a_code = 8'h41;
    b_col = 1; b_row = 0; b_code = 8'h42; clear_req = 1'b0;
    cursor_col = 8'd1; cursor_row = 8'd1;
    clr_left = NCELL; favour_b = 1'b0; exp_err = 1'b0; exp_pix = 1'b0;
    p1_v = 1'b0; p1_cur = 1'b0; p1_code = 0; rises = 0; prev_vs = 1'b0;
    for (int i = 0; i < NCELL; i++) mem[i] = 8'hxx;

    repeat (3) @(negedge clk);
    check("rst_pix", pix_out, 0);
    check("rst_err", err_oor, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_busy", clear_busy, 1);
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;

    // Mandatory clear after reset: measure its length while scanning pixels.
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (clear_busy) cnt++;
      char_x = 8'($urandom_range(0, 39)); char_y = 8'($urandom_range(0, 19));
      rand_ascii();
      cycle();
    end
    check("clear_len", cnt, NCELL);

    // Every cell holds a space after the clear.
    one_hot_ascii(8'h20);
    for (int i = 0; i < NCELL + 2; i++) begin
      char_x = 8'((i % NCELL) % COLS); char_y = 8'((i % NCELL) / COLS);
      cycle();
    end

    // A writes 'A' at (0,0), then read it back through the pixel pipeline.
    a_valid = 1'b1; a_col = 0; a_row = 0; a_code = 8'h41;
    cycle();
    check("t2_a_grant", g_a_grant, 1);
    a_valid = 1'b0;
    char_x = 0; char_y = 0; one_hot_ascii(8'h41);
    cycle(); cycle();
    check("t2_pix", pix_out, 1);

    // Both producers held valid: grants alternate.
    a_valid = 1'b1; b_valid = 1'b1;
    a_col = 3; a_row = 4; b_col = 5; b_row = 6;
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      a_code = 8'($urandom); b_code = 8'($urandom);
      cycle();
      grants += int'(g_a_grant) + int'(g_b_grant);
    end
    check("t3_grants", grants, 4);
    a_valid = 1'b0; b_valid = 1'b0;

    // B writes out of range.
    b_valid = 1'b1; b_col = 40; b_row = 2; b_code = 8'h55;
    cycle();
    check("t4_b_grant", g_b_grant, 1);
    check("t4_err", err_oor, 1);
    b_valid = 1'b0;
    char_x = 40; char_y = 2; ascii_char = '1;
    cycle(); cycle();
    check("t4_pix", pix_out, 0);

    // Clear request beats a same-cycle A request; A goes through once idle.
    clear_req = 1'b1; a_valid = 1'b1; a_col = 7; a_row = 7; a_code = 8'h33;
    cycle();
    check("t5_a_blocked", g_a_grant, 0);
    clear_req = 1'b0;
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (clear_busy) cnt++;
      char_x = 8'($urandom_range(0, 39)); char_y = 8'($urandom_range(0, 19));
      rand_ascii();
      cycle();
      seen = g_a_grant;
    end
    check("t5_grant_seen", seen, 1);
    check("t5_clear_len", cnt, NCELL);
    a_valid = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      a_valid = ($urandom_range(0, 2) != 0); b_valid = ($urandom_range(0, 2) != 0);
      a_col = 8'($urandom_range(0, 39)); a_row = 8'($urandom_range(0, 19));
      b_col = 8'($urandom_range(0, 39)); b_row = 8'($urandom_range(0, 19));
      a_code = 8'($urandom); b_code = 8'($urandom);
      clear_req = ($urandom_range(0, 399) == 0);
      char_x = 8'($urandom_range(0, 39)); char_y = 8'($urandom_range(0, 19));
      rand_ascii();
      cycle();
    end
    a_valid = 1'b0; b_valid = 1'b0; clear_req = 1'b0;
    for (int i = 0; i < 600 && clear_busy; i++) cycle();
    check("idle_after_random", clear_busy, 0);

`ifdef CURSOR_BLINK_EN
    // Cursor at (1,1): blank glyph shows inverted after BLINK rises, plain after 2*BLINK.
    char_x = 1; char_y = 1; ascii_char = '0;
    for (int r = 0; r < BLINK; r++) begin
      vsync = 1'b1; cycle(); vsync = 1'b0; cycle();
    end
    cycle(); cycle();
    check("cursor_on", pix_out, 1);
    for (int r = 0; r < BLINK; r++) begin
      vsync = 1'b1; cycle(); vsync = 1'b0; cycle();
    end
    cycle(); cycle();
    check("cursor_off", pix_out, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
